// File: rtl/sv_uart_tx_arb.sv
// sv_uart_tx_arb: merges NUM_SRC byte streams onto one UART TX stream, one non-preemptive burst per grant.
// Latency: 1 cycle from source handshake to m_axis_tvalid; each arbitration costs one IDLE cycle.
// Backpressure: only the granted source sees ready, and only while the output register is empty or draining.
//
// Ports:
//   iclk, irst            clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready   per-source streams, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_tdata/tvalid/tready         merged stream towards the UART transmitter
//   ogrant                one-hot current owner, zero when idle
//   obusy                 high while a grant is held
// Option macro: SV_UART_TX_ARB_PRIO_EN gives source 0 absolute priority at every IDLE arbitration;
// sources 1..NUM_SRC-1 stay round robin among themselves.
module sv_uart_tx_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [NUM_SRC-1:0]            ogrant,
    output logic                          obusy
);
    localparam int         PTR_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [8:0] BURST_LAST = 9'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant_idx;
    logic [NUM_SRC-1:0]    grant;
    logic [8:0]            burst_cnt;
    logic [DATA_WIDTH-1:0] out_dat;
    logic                  out_vld;

    logic                  out_free;
    logic                  beat_acc;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] src_dat;
    logic                  src_last;
    logic [NUM_SRC-1:0]    rr_req;
    logic                  pick_vld;
    logic [PTR_W-1:0]      pick_idx;

    // Output register may take a new byte when empty or being emptied this cycle.
    assign out_free      = ~out_vld | m_axis_tready;
    assign s_axis_tready = (state == GRANT) ? (grant & {NUM_SRC{out_free}}) : '0;
    assign beat_acc      = |(s_axis_tvalid & s_axis_tready);
    // Release on tlast or on the beat that brings the count to MAX_BURST.
    assign beat_last     = src_last | (burst_cnt == BURST_LAST);

    assign m_axis_tdata  = out_dat;
    assign m_axis_tvalid = out_vld;
    assign ogrant        = grant;
    assign obusy         = (state == GRANT);

    always_comb begin
        src_dat  = '0;
        src_last = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                src_dat  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                src_last = s_axis_tlast[i];
            end
        end
    end

`ifdef SV_UART_TX_ARB_PRIO_EN
    // Source 0 is handled by the override below, so the rotation only covers 1..NUM_SRC-1.
    assign rr_req = s_axis_tvalid & {{(NUM_SRC-1){1'b1}}, 1'b0};
`else
    assign rr_req = s_axis_tvalid;
`endif

    // First requester at or after rr_ptr, wrapping NUM_SRC-1 -> 0.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        idx_p    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx_p = PTR_W'(idx);
            if (!pick_vld && rr_req[idx_p]) begin
                pick_vld = 1'b1;
                pick_idx = idx_p;
            end
        end
`ifdef SV_UART_TX_ARB_PRIO_EN
        if (s_axis_tvalid[0]) begin
            pick_vld = 1'b1;
            pick_idx = '0;
        end
`endif
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant     <= '0;
            burst_cnt <= '0;
            out_vld   <= 1'b0;
            out_dat   <= '0;
        end else begin
            if (beat_acc) begin
                out_dat <= src_dat;
                out_vld <= 1'b1;
            end else if (m_axis_tready) begin
                out_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Wait until the buffered byte can leave so it is never overwritten.
                    if (pick_vld && out_free) begin
                        state     <= GRANT;
                        grant_idx <= pick_idx;
                        grant     <= NUM_SRC'(1) << pick_idx;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (beat_acc) begin
                        burst_cnt <= burst_cnt + 9'd1;
                        if (beat_last) begin
                            state  <= IDLE;
                            grant  <= '0;
                            rr_ptr <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sv_uart_tx_arb.md
SV_UART_TX_ARB -- requirements
Module: sv_uart_tx_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of every stream.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of requesters (legal range 2..16).
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per grant (legal range 1..256).
REQ-004 SHALL have port iclk  input  1  single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port irst  input  1  synchronous active-high reset.
REQ-006 SHALL have port s_axis_tdata  input  NUM_SRC*DATA_WIDTH  source data, source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port s_axis_tvalid  input  NUM_SRC  per-source valid.
REQ-008 SHALL have port s_axis_tlast  input  NUM_SRC  per-source end of message.
REQ-009 SHALL have port s_axis_tready  output  NUM_SRC  per-source ready.
REQ-010 SHALL have port m_axis_tdata  output  DATA_WIDTH  byte to the UART transmitter.
REQ-011 SHALL have port m_axis_tvalid  output  1  output valid.
REQ-012 SHALL have port m_axis_tready  input  1  transmitter ready.
REQ-013 SHALL have port ogrant  output  NUM_SRC  one-hot current owner, zero when idle.
REQ-014 SHALL have port obusy  output  1  high in state GRANT.

Function
REQ-015 SHALL implement states IDLE and GRANT.
REQ-016 IDLE: if any s_axis_tvalid is high, SHALL pick the first valid source at or after rr_ptr (round robin, wrapping NUM_SRC-1 -> 0), set ogrant, clear the burst counter and enter GRANT on the next cycle. All s_axis_tready SHALL be low in IDLE.
REQ-017 GRANT: s_axis_tready[g] SHALL be (m_axis_tready | ~m_axis_tvalid) and all other readies SHALL be 0.
REQ-018 The output SHALL be a single register stage. An accepted source beat SHALL load m_axis_tdata and set m_axis_tvalid on the next cycle. m_axis_tvalid SHALL clear after an output handshake with no new load. The latency from source handshake to m_axis_tvalid is 1 cycle.
REQ-019 m_axis_tdata/m_axis_tvalid SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 The burst counter SHALL increment per accepted source beat. It SHALL be 9 bits wide and SHALL never wrap within a grant.
REQ-021 The grant SHALL release (GRANT -> IDLE next cycle) on the accepted beat with s_axis_tlast[g]=1, or on the accepted beat that makes the count equal MAX_BURST, whichever comes first.
REQ-022 On release, rr_ptr SHALL become (g+1) mod NUM_SRC. The buffered last byte SHALL drain normally while in IDLE.
REQ-023 A new grant SHALL NOT be issued until m_axis_tvalid=0 or a handshake occurs in that cycle, so no byte is overwritten.
REQ-024 If s_axis_tvalid[g] drops mid-grant, the arbiter SHALL keep the grant and wait, with no timeout.
REQ-025 Changes to tvalid on non-granted sources SHALL NOT affect the current grant.

Reset
REQ-026 While irst=1: state=IDLE, rr_ptr=0, burst counter=0, m_axis_tvalid=0, m_axis_tdata=0, ogrant=0, obusy=0, all s_axis_tready=0.
REQ-027 Reset mid-burst SHALL discard the buffered byte. The first grant after reset SHALL go to the lowest-index valid source.

Configuration
REQ-028 With macro SV_UART_TX_ARB_PRIO_EN defined, source 0 SHALL win every IDLE arbitration when valid, ignoring rr_ptr. Sources 1..NUM_SRC-1 SHALL stay round robin among themselves. Bursts SHALL remain non-preemptive.
REQ-029 Without SV_UART_TX_ARB_PRIO_EN, all sources SHALL be pure round robin per REQ-016.

Verification
REQ-030 Single source 1 sends 0xA5 with tlast, m_axis_tready=1 -> m_axis_tdata=0xA5 for exactly one cycle, ogrant=4'b0010 then 0, rr_ptr=2.
REQ-031 Sources 0 and 2 each hold one tlast byte (0x11, 0x22) from reset -> output order 0x11, 0x22. Next arbitration from rr_ptr=3 with sources 0 and 2 valid again picks source 0.
REQ-032 MAX_BURST=4, source 3 streams 10 bytes without tlast while source 1 is valid -> after 4 bytes the grant moves to source 1, then returns to source 3.
REQ-033 m_axis_tready held 0 for 20 cycles mid-burst -> m_axis_tvalid=1 and data stable, s_axis_tready[g]=0, no byte lost or duplicated.
REQ-034 irst asserted for 1 cycle during the third byte of a burst -> all outputs reach reset values next cycle, and the next grant goes to the lowest valid source.
REQ-035 With SV_UART_TX_ARB_PRIO_EN, sources 0 and 1 always valid with 1-byte messages -> source 0 wins every grant. Without the macro, grants alternate 0, 1, 0, 1.
